// File: rtl/matrix_pkg.sv
// Shared constants for the 3x3 matrix multiplier datapath.
//   EW        - operand element width in bits
//   N         - matrix dimension (N x N elements)
//   MAT_W     - width of one packed operand matrix
//   OUT_EW    - width of one product element
//   OUT_W     - width of the packed product matrix
//   FRAME_LEN - elements per A+B frame on the serial input
// Also holds the loader FSM state encodings and a packing helper.
package matrix_pkg;

    localparam int EW        = 3;
    localparam int N         = 3;
    localparam int MAT_W     = EW * N * N;
    localparam int OUT_EW    = 8;
    localparam int OUT_W     = OUT_EW * N * N;
    localparam int FRAME_LEN = 2 * N * N;

    // Loader FSM states.
    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Bit offset of element k inside a packed matrix of ew-bit elements.
    function automatic int elem_off(input int k, input int ew);
        return k * ew;
    endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel operand loader for the 3x3 matrix multiplier.
// Collects a row-major stream of A (elements 0..N*N-1) then B
// (elements N*N..2*N*N-1) into staging registers, publishes both as
// registered buses on the last element, then waits out the
// multiplier's fixed pipeline latency and pulses res_valid.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   in_data      serial element
//   in_valid     in_data valid
//   in_last      marks the final element of an A+B frame
//   in_ready     loader accepts an element this cycle
//   matrix_inp1  operand A to multiplier (element k at bits [EW*k +: EW])
//   matrix_inp2  operand B to multiplier
//   res_valid    one-cycle pulse: multiplier output matches current operands
//   frame_err    one-cycle pulse on an in_last framing violation
module matrix_operand_loader #(
    parameter int EW       = 3,
    parameter int N        = 3,
    parameter int PIPE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [EW-1:0]       in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [EW*N*N-1:0]   matrix_inp1,
    output logic [EW*N*N-1:0]   matrix_inp2,
    output logic                res_valid,
    output logic                frame_err
);

    import matrix_pkg::*;

    localparam int NN    = N * N;
    localparam int FRAME = 2 * NN;
    localparam int MW    = EW * NN;
    localparam int CNT_W = $clog2(FRAME);
    localparam int LAT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] elem_cnt_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic [EW-1:0]    stage_reg [FRAME];
    logic [MW-1:0]    inp1_reg;
    logic [MW-1:0]    inp2_reg;
    logic             frame_err_reg;

    logic             loading;
    logic             last_slot;
    logic             lat_done;
    logic [MW-1:0]    next_a;
    logic [MW-1:0]    next_b;

    assign loading   = (state_reg == ST_LOAD);
    assign last_slot = (elem_cnt_reg == CNT_W'(FRAME - 1));
    assign lat_done  = (state_reg == ST_WAIT) && (lat_cnt_reg == LAT_W'(PIPE_LAT));

    // Parallel view of the staging slots. The final B element is taken
    // straight from in_data so the operands publish on the same edge that
    // accepts it, rather than one cycle later.
    genvar gi;
    generate
        for (gi = 0; gi < NN; gi++) begin : g_pack
            localparam int OFF = elem_off(gi, EW);
            assign next_a[OFF +: EW] = stage_reg[gi];
            if (gi == NN - 1) begin : g_tail
                assign next_b[OFF +: EW] = in_data;
            end else begin : g_body
                assign next_b[OFF +: EW] = stage_reg[NN + gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_LOAD;
            elem_cnt_reg  <= '0;
            lat_cnt_reg   <= '0;
            inp1_reg      <= '0;
            inp2_reg      <= '0;
            frame_err_reg <= 1'b0;
            for (int i = 0; i < FRAME; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            frame_err_reg <= 1'b0;
            if (state_reg == ST_LOAD) begin
                if (in_valid) begin
                    stage_reg[elem_cnt_reg] <= in_data;
                    if (last_slot) begin
                        // Frame complete: publish operands, start latency count.
                        inp1_reg      <= next_a;
                        inp2_reg      <= next_b;
                        elem_cnt_reg  <= '0;
                        lat_cnt_reg   <= LAT_W'(1);
                        state_reg     <= ST_WAIT;
                        // Missing in_last is flagged but the frame is still used.
                        frame_err_reg <= ~in_last;
                    end else if (in_last) begin
                        // Early in_last: drop the partial frame and resync.
                        elem_cnt_reg  <= '0;
                        frame_err_reg <= 1'b1;
                    end else begin
                        elem_cnt_reg  <= elem_cnt_reg + CNT_W'(1);
                    end
                end
            end else begin
                if (lat_done) begin
                    lat_cnt_reg <= '0;
                    state_reg   <= ST_LOAD;
                end else begin
                    lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                end
            end
        end
    end

    assign in_ready    = loading;
    assign res_valid   = lat_done;
    assign frame_err   = frame_err_reg;
    assign matrix_inp1 = inp1_reg;
    assign matrix_inp2 = inp2_reg;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Randomised bench for matrix_operand_loader: a queue-based frame model
// predicts every output each cycle, a matrix-product scoreboard checks
// each res_valid, and directed scenarios pin latency, framing errors,
// reset during the wait phase, and literal operand/product values.
module tb_matrix_operand_loader;

    localparam int PIPE_LAT = 3;
    localparam int FRAME    = 18;

    localparam logic [26:0] A1_LIT = {3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [26:0] ID_LIT = {3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd1};
    localparam logic [71:0] C1_LIT = {8'd1, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [26:0] matrix_inp1;
    logic [26:0] matrix_inp2;
    logic        res_valid;
    logic        frame_err;

    matrix_operand_loader #(.EW(3), .N(3), .PIPE_LAT(PIPE_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .matrix_inp1(matrix_inp1),
        .matrix_inp2(matrix_inp2),
        .res_valid  (res_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference 3x3 product with 3-bit elements, 8-bit results.
    function automatic logic [71:0] matmul(input logic [26:0] a, input logic [26:0] b);
        logic [71:0] c;
        int s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'(a[3*(3*i+k) +: 3]) * int'(b[3*(3*k+j) +: 3]);
                end
                c[8*(3*i+j) +: 8] = 8'(s);
            end
        end
        return c;
    endfunction

    // ---------------- behavioural model ----------------
    // The model tracks the partial frame as a queue of elements and the
    // wait phase as a countdown of cycles until the loader is ready again.
    logic [2:0]  q[$];
    logic [53:0] pend[$];
    logic [26:0] m_a = '0;
    logic [26:0] m_b = '0;
    int          busy = 0;
    logic        m_err = 1'b0;
    bit          m_live = 1'b0;

    task automatic model_step();
        if (rst) begin
            q.delete();
            pend.delete();
            m_a = '0;
            m_b = '0;
            busy = 0;
            m_err = 1'b0;
            m_live = 1'b1;
        end else begin
            m_err = 1'b0;
            if (busy > 0) begin
                busy--;
            end else if (in_valid) begin
                q.push_back(in_data);
                if (q.size() == FRAME) begin
                    for (int k = 0; k < 9; k++) begin
                        m_a[3*k +: 3] = q[k];
                        m_b[3*k +: 3] = q[9+k];
                    end
                    busy = PIPE_LAT;
                    m_err = ~in_last;
                    pend.push_back({m_a, m_b});
                    q.delete();
                end else if (in_last) begin
                    q.delete();
                    m_err = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    int rv_cnt = 0;
    int fe_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("in_ready", 72'(in_ready), 72'(busy == 0));
            chk("res_valid", 72'(res_valid), 72'(busy == 1));
            chk("frame_err", 72'(frame_err), 72'(m_err));
            chk("matrix_inp1", 72'(matrix_inp1), 72'(m_a));
            chk("matrix_inp2", 72'(matrix_inp2), 72'(m_b));
            if (frame_err) fe_cnt++;
            if (res_valid) begin
                rv_cnt++;
                if (pend.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL res_valid_extra: got pulse expected none at %0t", $time);
                end else begin
                    logic [53:0] e;
                    e = pend.pop_front();
                    chk("product", matmul(matrix_inp1, matrix_inp2), matmul(e[53:27], e[26:0]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0] fr[FRAME];

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Presents one element; returns after driving it in a cycle where the
    // model says it will be accepted at the next edge. While the loader is
    // busy, junk transfers are offered to confirm they are ignored.
    task automatic send_elem(input logic [2:0] d, input logic last, input int gap_pct);
        int tries;
        bit done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (busy == 0 && int'($urandom_range(99)) >= gap_pct) begin
                in_valid = 1'b1;
                in_data  = d;
                in_last  = last;
                done     = 1;
            end else begin
                in_valid = (busy != 0) ? 1'($urandom_range(1)) : 1'b0;
                in_data  = 3'($urandom_range(7));
                in_last  = 1'($urandom_range(1));
            end
            tries++;
            if (!done && tries > 500) begin
                chk("send_timeout", 72'(tries), 72'(0));
                done = 1;
            end
        end
    endtask

    task automatic send_frame(input int n, input int last_idx, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            send_elem(fr[i], 1'(i == last_idx), gap_pct);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < FRAME; i++) fr[i] = 3'($urandom_range(7));
    endtask

    initial begin
        int k;
        int nr;
        int rv_seen;
        int rv0;
        int fe0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_inp1", 72'(matrix_inp1), 72'(0));
        chk("reset_ready", 72'(in_ready), 72'(1));

        // A = 1..7,0,1 ; B = identity ; latency from 18th accept.
        for (int i = 0; i < 9; i++) begin
            fr[i]   = 3'((i + 1) % 8);
            fr[9+i] = (i == 0 || i == 4 || i == 8) ? 3'd1 : 3'd0;
        end
        send_frame(FRAME, FRAME - 1, 0);
        k = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            k++;
        end while (!res_valid && k < 40);
        chk("latency", 72'(k), 72'(PIPE_LAT));
        chk("inp1_literal", 72'(matrix_inp1), 72'(A1_LIT));
        chk("inp2_literal", 72'(matrix_inp2), 72'(ID_LIT));
        chk("product_literal", matmul(matrix_inp1, matrix_inp2), C1_LIT);
        idle(2);

        // All-7 operands: every C(i,j) = 147, PIPE_LAT not-ready cycles.
        for (int i = 0; i < FRAME; i++) fr[i] = 3'd7;
        send_frame(FRAME, FRAME - 1, 0);
        nr = 0;
        rv_seen = 0;
        repeat (PIPE_LAT + 6) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!in_ready) nr++;
            if (res_valid) begin
                rv_seen++;
                chk("all7_product", matmul(matrix_inp1, matrix_inp2), {9{8'h93}});
            end
        end
        chk("all7_busy_cycles", 72'(nr), 72'(PIPE_LAT));
        chk("all7_pulses", 72'(rv_seen), 72'(1));

        // in_last on the 5th element, then a clean frame from k=0.
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        rand_frame();
        send_frame(5, 4, 30);
        idle(5);
        chk("early_last_err", 72'(fe_cnt - fe0), 72'(1));
        chk("early_last_rv", 72'(rv_cnt - rv0), 72'(0));
        rand_frame();
        send_frame(FRAME, FRAME - 1, 30);
        idle(PIPE_LAT + 3);
        chk("resync_rv", 72'(rv_cnt - rv0), 72'(1));

        // in_last missing on the 18th element.
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        rand_frame();
        send_frame(FRAME, -1, 0);
        idle(PIPE_LAT + 3);
        chk("nolast_err", 72'(fe_cnt - fe0), 72'(1));
        chk("nolast_rv", 72'(rv_cnt - rv0), 72'(1));

        // Reset in WAIT (lat_cnt=1) with in_valid high.
        rv0 = rv_cnt;
        rand_frame();
        fr[0] = 3'd5;
        send_frame(FRAME, FRAME - 1, 0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'd6;
        in_last  = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_wait_inp1", 72'(matrix_inp1), 72'(0));
        chk("rst_wait_inp2", 72'(matrix_inp2), 72'(0));
        chk("rst_wait_ready", 72'(in_ready), 72'(1));
        idle(PIPE_LAT + 3);
        chk("rst_wait_rv", 72'(rv_cnt - rv0), 72'(0));
        rand_frame();
        send_frame(FRAME, FRAME - 1, 0);
        idle(PIPE_LAT + 3);
        chk("post_rst_rv", 72'(rv_cnt - rv0), 72'(1));

        // 100 random frames with ~50% in_valid gaps.
        rv0 = rv_cnt;
        for (int f = 0; f < 100; f++) begin
            rand_frame();
            send_frame(FRAME, FRAME - 1, 50);
        end
        idle(PIPE_LAT + 5);
        chk("random_rv", 72'(rv_cnt - rv0), 72'(100));
        chk("pending_left", 72'(pend.size()), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
